// File: rtl/seq111_pkg.sv
// seq111_pkg: shared state encodings and default width for the "111" scan controller
//   ctrl_t : controller states IDLE/SHIFT/DONE
//   det_t  : detector states S0..S3, encoded as {Q1,Q0}
package seq111_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_t;
endpackage

// File: rtl/seq111_core.sv
// seq111_core: overlapping "111" Moore detector
//   clk, reset (sync, active-low), clr (load S0), en (advance on S), S (input bit)
//   Y (state == S3), Q1/Q0 (state bits)
module seq111_core
  import seq111_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic S,
  output logic Y,
  output logic Q1,
  output logic Q0
);
  det_t st;
  always_ff @(posedge clk)
    if (!reset || clr) st <= S0;
    else if (en) st <= !S ? S0 : st == S3 ? S3 : det_t'(st + 2'd1);
  assign {Q1, Q0} = st;
  assign Y = Q1 & Q0;
endmodule

// File: rtl/seq111_scan_ctrl.sv
// seq111_scan_ctrl: feeds a word LSB-first into the "111" detector, counting matches
//   clk, reset (sync, active-low), start, abort, data_in[WIDTH]
//   busy, done, aborted, S, bit_idx, Y, Q1, Q0, match_count, found, first_match_idx
module seq111_scan_ctrl
  import seq111_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             S,
  output logic [IDX_W-1:0] bit_idx,
  output logic             Y,
  output logic             Q1,
  output logic             Q0,
  output logic [CNT_W-1:0] match_count,
  output logic             found,
  output logic [IDX_W-1:0] first_match_idx
);
  ctrl_t state;
  logic [WIDTH-1:0] sreg;
  logic go, adv, last, hit;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign S    = busy & sreg[0];
  assign go   = state == IDLE && start;
  assign adv  = busy && !abort;
  assign last = bit_idx == IDX_W'(WIDTH - 1);
  // detector lands in S3 on this edge when it sits in S2/S3 (Q1=1) and sees a 1
  assign hit  = adv && S && Q1;
  seq111_core u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (go),
    .en   (adv),
    .S    (S),
    .Y    (Y),
    .Q1   (Q1),
    .Q0   (Q0)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state           <= IDLE;
      sreg            <= '0;
      bit_idx         <= '0;
      match_count     <= '0;
      found           <= 1'b0;
      first_match_idx <= '0;
      aborted         <= 1'b0;
    end else begin
      aborted <= 1'b0;
      if (go) begin
        state           <= SHIFT;
        sreg            <= data_in;
        bit_idx         <= '0;
        match_count     <= '0;
        found           <= 1'b0;
        first_match_idx <= '0;
      end else if (busy && abort) begin
        state   <= IDLE;
        aborted <= 1'b1;
      end else if (busy) begin
        state   <= last ? DONE : SHIFT;
        sreg    <= sreg >> 1;
        bit_idx <= last ? bit_idx : bit_idx + IDX_W'(1);
        if (hit) begin
          match_count <= match_count + CNT_W'(1);
          found       <= 1'b1;
          if (!found) first_match_idx <= bit_idx;
        end
      end else if (done) state <= IDLE;
    end
endmodule

// File: tb/tb_seq111_scan_ctrl.sv
// tb_seq111_scan_ctrl: directed self-checking bench for seq111_scan_ctrl
module tb_seq111_scan_ctrl;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [W-1:0] data_in = '0;
  logic busy, done, aborted, S, Y, Q1, Q0, found;
  logic [3:0] bit_idx, first_match_idx;
  logic [4:0] match_count;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  seq111_scan_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .data_in(data_in),
    .busy(busy), .done(done), .aborted(aborted), .S(S), .bit_idx(bit_idx),
    .Y(Y), .Q1(Q1), .Q0(Q0), .match_count(match_count), .found(found),
    .first_match_idx(first_match_idx)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [W-1:0] w);
    data_in = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_idx", bit_idx, 0);
  endtask
  // Called in the first SHIFT cycle; walks all bits, then checks DONE and the following IDLE cycle.
  // poke>=0 pulses start at that bit and again in the DONE cycle (left high for the caller).
  task automatic scan_rest(input logic [W-1:0] w, input int cnt, input logic fnd, input int fst, input int poke);
    int run = 0;
    for (int i = 0; i < W; i++) begin
      chk("bit_idx", bit_idx, i);
      chk("S", S, w[i]);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("Y", Y, run >= 3);
      run = w[i] ? run + 1 : 0;
      if (i == poke) begin
        start = 1'b1;
        data_in = '0;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_aborted", aborted, 0);
    chk("done_S", S, 0);
    chk("done_idx", bit_idx, W - 1);
    chk("done_Y", Y, run >= 3);
    chk("count", match_count, cnt);
    chk("found", found, fnd);
    chk("first", first_match_idx, fst);
    if (poke >= 0) begin
      start = 1'b1;
      data_in = '0;
    end
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("hold_count", match_count, cnt);
    chk("hold_found", found, fnd);
    chk("hold_first", first_match_idx, fst);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_S", S, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_Q", {Y, Q1, Q0}, 0);
    chk("rst_count", match_count, 0);
    chk("rst_found", found, 0);
    chk("rst_first", first_match_idx, 0);
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", {busy, aborted}, 0);
    launch(16'h8756);
    scan_rest(16'h8756, 1, 1'b1, 10, -1);
    launch(16'hFFFF);
    scan_rest(16'hFFFF, 14, 1'b1, 2, -1);
    launch(16'h7777);
    scan_rest(16'h7777, 4, 1'b1, 2, -1);
    launch(16'h0000);
    scan_rest(16'h0000, 0, 1'b0, 0, -1);
    launch(16'hFFFF);
    repeat (5) @(negedge clk);
    chk("abort_idx", bit_idx, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("aborted", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", match_count, 3);
    chk("abort_first", first_match_idx, 2);
    chk("abort_Y", Y, 1);
    chk("abort_S", S, 0);
    @(negedge clk);
    chk("aborted_pulse", aborted, 0);
    chk("abort_no_done", done, 0);
    chk("abort_hold", match_count, 3);
    launch(16'h7777);
    scan_rest(16'h7777, 4, 1'b1, 2, 3);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_count", match_count, 0);
    chk("restart_found", found, 0);
    chk("restart_idx", bit_idx, 0);
    scan_rest(16'h0000, 0, 1'b0, 0, -1);
    launch(16'hFFFF);
    repeat (8) @(negedge clk);
    chk("pre_reset_idx", bit_idx, 8);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {done, aborted, S}, 0);
    chk("mid_rst_idx", bit_idx, 0);
    chk("mid_rst_Q", {Y, Q1, Q0}, 0);
    chk("mid_rst_count", match_count, 0);
    chk("mid_rst_found", found, 0);
    chk("mid_rst_first", first_match_idx, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_quiet", {busy, done, aborted}, 0);
    end
    data_in = 16'h7777;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1);
    scan_rest(16'h7777, 4, 1'b1, 2, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
